song_tutor: RTL and testbench

- Parametrised successor to the fixed-melody note-tracking FSM in the piano design.
- Holds a loadable melody of up to MAX_LEN notes and tracks the player's key presses against it, step by step.
- Adds what the fixed block lacks: strict and lenient modes, mistake counting, an idle-time hint LED, abort, and done/mistake pulses.
- Sits between the keypad note decoder (a stable, debounced note code) and the LED/score display logic.

---
 rtl/song_tutor_pkg.sv | 26 ++
 rtl/song_tutor_ram.sv | 23 ++
 rtl/song_tutor.sv | 172 +++++++++++++++++
 tb/tb_song_tutor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/song_tutor_pkg.sv
// Shared note codes, FSM state encoding and the note-to-LED helper for the melody tutor.
package song_tutor_pkg;

  localparam logic [3:0] NOTE_D = 4'd2;
  localparam logic [3:0] NOTE_E = 4'd3;
  localparam logic [3:0] NOTE_F = 4'd4;
  localparam logic [3:0] NOTE_G = 4'd5;
  localparam logic [3:0] NOTE_A = 4'd6;
  localparam logic [3:0] NOTE_B = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_PRESS   = 2'd1,
    S_WAIT_REL     = 2'd2,
    S_WAIT_REL_BAD = 2'd3
  } state_t;

  // Code 1 lights bit 0; codes outside 1..led_w (led_w <= 32) light nothing.
  function automatic logic [31:0] note_to_led(input logic [15:0] code, input int led_w);
    logic [31:0] v;
    v = '0;
    if (code != 16'd0 && int'(code) <= led_w) v = 32'd1 << (code - 16'd1);
    return v;
  endfunction

endpackage

// File: rtl/song_tutor_ram.sv
// Melody store: one synchronous write port, one combinational read port, no reset.
module song_tutor_ram
  import song_tutor_pkg::*;
#(
  parameter int NOTE_W = 4,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [NOTE_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [NOTE_W-1:0] o_rdata
);
  logic [NOTE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/song_tutor.sv
// Melody tutor: follows key presses against the stored melody, counts mistakes and
// lights a hint LED for the awaited note after a long idle period.
module song_tutor
  import song_tutor_pkg::*;
#(
  parameter int NOTE_W    = 4,
  parameter int NOTE_NONE = 0,
  parameter int MAX_LEN   = 32,
  parameter int HINT_CYC  = 50000000,
  parameter int MISS_W    = 8,
  parameter int LED_W     = 8,
  localparam int IW       = $clog2(MAX_LEN)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NOTE_W-1:0] note,
  input  logic              start,
  input  logic              abort,
  input  logic              mode_strict,
  input  logic [IW:0]       song_len,
  input  logic              load_we,
  input  logic [IW-1:0]     load_addr,
  input  logic [NOTE_W-1:0] load_note,
  output logic              busy,
  output logic [NOTE_W-1:0] expected,
  output logic [IW:0]       progress,
  output logic              done,
  output logic              mistake,
  output logic [MISS_W-1:0] mistakes,
  output logic              hint,
  output logic [LED_W-1:0]  led
);
  localparam int TW = $clog2(HINT_CYC + 1);
  localparam logic [NOTE_W-1:0] NONE_C  = NOTE_W'(NOTE_NONE);
  localparam logic [TW-1:0]     HINT_C  = TW'(HINT_CYC);
  localparam logic [IW:0]       LEN_MAX = (IW+1)'(MAX_LEN);
  localparam logic [IW:0]       ONE_P   = (IW+1)'(1);

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [IW:0]       r_len, w_len_nxt, r_progress, w_prog_nxt, w_last;
  logic              r_strict, w_strict_nxt;
  logic [MISS_W-1:0] r_mistakes, w_miss_nxt;
  logic [TW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_busy, w_busy_nxt, r_done, w_done_nxt, r_mistake, w_mistake_nxt;
  logic              r_hint, w_hint_nxt;
  logic [NOTE_W-1:0] r_expected, w_exp_nxt, w_rd_note;
  logic [LED_W-1:0]  r_led;
  logic              w_ram_we, w_len_ok;

  assign w_ram_we = load_we && (r_state == S_IDLE);
  assign w_len_ok = (song_len != '0) && (song_len <= LEN_MAX);
  assign w_last   = r_len - ONE_P;

  song_tutor_ram #(.NOTE_W(NOTE_W), .DEPTH(MAX_LEN), .AW(IW)) u_ram (
    .CLK     (CLK),
    .i_we    (w_ram_we),
    .i_waddr (load_addr),
    .i_wdata (load_note),
    .i_raddr (w_idx_nxt),
    .o_rdata (w_rd_note)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_len_nxt     = r_len;
    w_strict_nxt  = r_strict;
    w_prog_nxt    = r_progress;
    w_miss_nxt    = r_mistakes;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_mistake_nxt = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && w_len_ok) begin
            w_len_nxt    = song_len;
            w_strict_nxt = mode_strict;
            w_idx_nxt    = '0;
            w_prog_nxt   = '0;
            w_miss_nxt   = '0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_WAIT_PRESS;
          end
        end
        S_WAIT_PRESS: begin
          if (note != NONE_C) begin
            if (note == r_expected) begin
              w_state_nxt = S_WAIT_REL;
            end else begin
              w_mistake_nxt = 1'b1;
              if (r_mistakes != '1) w_miss_nxt = r_mistakes + MISS_W'(1);
              if (r_strict) begin
                w_idx_nxt  = '0;
                w_prog_nxt = '0;
              end
              w_state_nxt = S_WAIT_REL_BAD;
            end
          end
        end
        S_WAIT_REL: begin
          // Key changes while held are not new presses; only release advances.
          if (note == NONE_C) begin
            w_prog_nxt = r_progress + ONE_P;
            if ({1'b0, r_idx} == w_last) begin
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_IDLE;
            end else begin
              w_idx_nxt   = r_idx + IW'(1);
              w_state_nxt = S_WAIT_PRESS;
            end
          end
        end
        S_WAIT_REL_BAD: begin
          if (note == NONE_C) w_state_nxt = S_WAIT_PRESS;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_exp_nxt  = (w_state_nxt == S_IDLE) ? NONE_C : w_rd_note;
  assign w_cnt_nxt  = (r_state == S_WAIT_PRESS && w_state_nxt == S_WAIT_PRESS) ?
                      ((r_cnt == HINT_C) ? r_cnt : r_cnt + TW'(1)) : '0;
  assign w_hint_nxt = (w_state_nxt == S_WAIT_PRESS) && (w_cnt_nxt == HINT_C);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_strict   <= 1'b0;
      r_progress <= '0;
      r_mistakes <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mistake  <= 1'b0;
      r_hint     <= 1'b0;
      r_expected <= NONE_C;
      r_led      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_len      <= w_len_nxt;
      r_strict   <= w_strict_nxt;
      r_progress <= w_prog_nxt;
      r_mistakes <= w_miss_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_mistake  <= w_mistake_nxt;
      r_hint     <= w_hint_nxt;
      r_expected <= w_exp_nxt;
      r_led      <= w_hint_nxt ? LED_W'(note_to_led(16'(w_exp_nxt), LED_W)) : '0;
    end
  end

  assign busy     = r_busy;
  assign expected = r_expected;
  assign progress = r_progress;
  assign done     = r_done;
  assign mistake  = r_mistake;
  assign mistakes = r_mistakes;
  assign hint     = r_hint;
  assign led      = r_led;
endmodule

// File: tb/tb_song_tutor.sv
// Bench for song_tutor: table of single-cycle vectors plus hand sequences, all
// expected outputs pushed to a scoreboard queue and popped after each clock edge.
module tb_song_tutor;
  import song_tutor_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] note = '0;
  logic       start = 1'b0, abort = 1'b0, mode_strict = 1'b0;
  logic [5:0] song_len = '0;
  logic       load_we = 1'b0;
  logic [4:0] load_addr = '0;
  logic [3:0] load_note = '0;
  logic       busy, done, mistake, hint_on;
  logic [3:0] expected;
  logic [5:0] progress;
  logic [7:0] mistakes, led;

  int n_checks = 0;
  int n_err = 0;

  song_tutor #(.NOTE_W(4), .NOTE_NONE(0), .MAX_LEN(32), .HINT_CYC(10), .MISS_W(8), .LED_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .note(note), .start(start), .abort(abort),
    .mode_strict(mode_strict), .song_len(song_len), .load_we(load_we),
    .load_addr(load_addr), .load_note(load_note), .busy(busy), .expected(expected),
    .progress(progress), .done(done), .mistake(mistake), .mistakes(mistakes),
    .hint(hint_on), .led(led)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       busy;
    logic [3:0] exp;
    logic [5:0] prog;
    logic       done;
    logic       mis;
    logic [7:0] miss;
    logic       hint;
    logic [7:0] led;
  } out_t;

  typedef struct packed {
    logic [3:0] note;
    logic       start;
    logic       abort;
    logic       strict;
    logic [5:0] len;
    out_t       o;
  } vec_t;

  out_t sb[$];
  vec_t vecs[$];

  function automatic out_t mo(input logic b, input logic [3:0] e, input logic [5:0] p,
                              input logic d, input logic m, input logic [7:0] ms,
                              input logic h, input logic [7:0] l);
    out_t r;
    r.busy = b; r.exp = e; r.prog = p; r.done = d;
    r.mis = m; r.miss = ms; r.hint = h; r.led = l;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic check_front(input string tag);
    out_t e;
    e = sb.pop_front();
    chk({tag, ".busy"},     32'(busy),     32'(e.busy));
    chk({tag, ".expected"}, 32'(expected), 32'(e.exp));
    chk({tag, ".progress"}, 32'(progress), 32'(e.prog));
    chk({tag, ".done"},     32'(done),     32'(e.done));
    chk({tag, ".mistake"},  32'(mistake),  32'(e.mis));
    chk({tag, ".mistakes"}, 32'(mistakes), 32'(e.miss));
    chk({tag, ".hint"},     32'(hint_on),  32'(e.hint));
    chk({tag, ".led"},      32'(led),      32'(e.led));
  endtask

  task automatic cycle(input logic [3:0] n, input logic s, input logic a, input out_t e,
                       input string tag);
    note = n; start = s; abort = a;
    sb.push_back(e);
    @(posedge CLK); #1;
    start = 1'b0; abort = 1'b0;
    check_front(tag);
  endtask

  task automatic load(input logic [4:0] a, input logic [3:0] n);
    load_we = 1'b1; load_addr = a; load_note = n;
    @(posedge CLK); #1;
    load_we = 1'b0;
  endtask

  task automatic addv(input logic [3:0] n, input logic s, input logic a, input logic st,
                      input logic [5:0] l, input out_t o);
    vec_t v;
    v.note = n; v.start = s; v.abort = a; v.strict = st; v.len = l; v.o = o;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    // happy path, lenient, E E F G
    addv(0, 1, 0, 0, 4, mo(1, 3, 0, 0, 0, 0, 0, 0));
    addv(3, 0, 0, 0, 4, mo(1, 3, 0, 0, 0, 0, 0, 0));
    addv(3, 0, 0, 0, 4, mo(1, 3, 0, 0, 0, 0, 0, 0));
    addv(0, 0, 0, 0, 4, mo(1, 3, 1, 0, 0, 0, 0, 0));
    addv(3, 0, 0, 0, 4, mo(1, 3, 1, 0, 0, 0, 0, 0));
    addv(0, 0, 0, 0, 4, mo(1, 4, 2, 0, 0, 0, 0, 0));
    addv(4, 0, 0, 0, 4, mo(1, 4, 2, 0, 0, 0, 0, 0));
    addv(5, 0, 0, 0, 4, mo(1, 4, 2, 0, 0, 0, 0, 0));
    addv(0, 0, 0, 0, 4, mo(1, 5, 3, 0, 0, 0, 0, 0));
    addv(5, 0, 0, 0, 4, mo(1, 5, 3, 0, 0, 0, 0, 0));
    addv(0, 0, 0, 0, 4, mo(0, 0, 4, 1, 0, 0, 0, 0));
    addv(0, 0, 0, 0, 4, mo(0, 0, 4, 0, 0, 0, 0, 0));
    addv(0, 1, 0, 0, 0, mo(0, 0, 4, 0, 0, 0, 0, 0));
    addv(0, 1, 0, 0, 33, mo(0, 0, 4, 0, 0, 0, 0, 0));
    // strict restart on D at step 2
    addv(0, 1, 0, 1, 4, mo(1, 3, 0, 0, 0, 0, 0, 0));
    addv(3, 0, 0, 1, 4, mo(1, 3, 0, 0, 0, 0, 0, 0));
    addv(0, 0, 0, 1, 4, mo(1, 3, 1, 0, 0, 0, 0, 0));
    addv(3, 0, 0, 1, 4, mo(1, 3, 1, 0, 0, 0, 0, 0));
    addv(0, 0, 0, 1, 4, mo(1, 4, 2, 0, 0, 0, 0, 0));
    addv(NOTE_D, 0, 0, 1, 4, mo(1, 3, 0, 0, 1, 1, 0, 0));
    addv(NOTE_D, 0, 0, 1, 4, mo(1, 3, 0, 0, 0, 1, 0, 0));
    addv(0, 0, 0, 1, 4, mo(1, 3, 0, 0, 0, 1, 0, 0));
    addv(0, 1, 0, 0, 2, mo(1, 3, 0, 0, 0, 1, 0, 0));
    addv(0, 0, 1, 0, 2, mo(0, 0, 0, 0, 0, 1, 0, 0));
    // lenient wrong note at step 2
    addv(0, 1, 0, 0, 4, mo(1, 3, 0, 0, 0, 0, 0, 0));
    addv(3, 0, 0, 0, 4, mo(1, 3, 0, 0, 0, 0, 0, 0));
    addv(0, 0, 0, 0, 4, mo(1, 3, 1, 0, 0, 0, 0, 0));
    addv(3, 0, 0, 0, 4, mo(1, 3, 1, 0, 0, 0, 0, 0));
    addv(0, 0, 0, 0, 4, mo(1, 4, 2, 0, 0, 0, 0, 0));
    addv(NOTE_A, 0, 0, 0, 4, mo(1, 4, 2, 0, 1, 1, 0, 0));
    addv(NOTE_B, 0, 0, 0, 4, mo(1, 4, 2, 0, 0, 1, 0, 0));
    addv(0, 0, 0, 0, 4, mo(1, 4, 2, 0, 0, 1, 0, 0));

    // reset state
    @(posedge CLK); #1;
    sb.push_back(mo(0, 0, 0, 0, 0, 0, 0, 0));
    check_front("reset");
    #2 RESET_N = 1'b1;
    @(posedge CLK); #1;
    load(0, NOTE_E); load(1, NOTE_E); load(2, NOTE_F); load(3, NOTE_G);
    sb.push_back(mo(0, 0, 0, 0, 0, 0, 0, 0));
    check_front("after_load");

    for (int i = 0; i < vecs.size(); i++) begin
      mode_strict = vecs[i].strict;
      song_len    = vecs[i].len;
      cycle(vecs[i].note, vecs[i].start, vecs[i].abort, vecs[i].o, $sformatf("tbl[%0d]", i));
    end

    // mistakes saturation, still at step 2 in lenient mode
    for (int i = 1; i <= 300; i++) begin
      m = (i + 1 > 255) ? 255 : i + 1;
      cycle(NOTE_A, 0, 0, mo(1, 4, 2, 0, 1, 8'(m), 0, 0), $sformatf("sat_p[%0d]", i));
      cycle(0, 0, 0, mo(1, 4, 2, 0, 0, 8'(m), 0, 0), $sformatf("sat_r[%0d]", i));
    end

    // hint: WAIT_PRESS was entered on the last release above, expected = F (4)
    for (int k = 1; k <= 11; k++)
      cycle(0, 0, 0, mo(1, 4, 2, 0, 0, 8'd255, (k >= 10), (k >= 10) ? 8'h08 : 8'h00),
            $sformatf("hint[%0d]", k));
    cycle(NOTE_F, 0, 0, mo(1, 4, 2, 0, 0, 8'd255, 0, 0), "hint_press");
    cycle(0, 0, 0, mo(1, 5, 3, 0, 0, 8'd255, 0, 0), "hint_rel");
    cycle(0, 0, 1, mo(0, 0, 3, 0, 0, 8'd255, 0, 0), "abort_mid");

    // control corner cases
    mode_strict = 1'b0; song_len = 6'd4;
    cycle(0, 1, 0, mo(1, 3, 0, 0, 0, 0, 0, 0), "ctl_start");
    load_we = 1'b1; load_addr = 5'd0; load_note = NOTE_B;
    cycle(0, 0, 0, mo(1, 3, 0, 0, 0, 0, 0, 0), "ctl_we_busy");
    load_we = 1'b0;
    cycle(0, 0, 1, mo(0, 0, 0, 0, 0, 0, 0, 0), "ctl_abort");
    cycle(0, 1, 1, mo(0, 0, 0, 0, 0, 0, 0, 0), "ctl_start_abort");
    song_len = 6'd40;
    cycle(0, 1, 0, mo(0, 0, 0, 0, 0, 0, 0, 0), "ctl_len40");
    song_len = 6'd4;
    cycle(0, 1, 0, mo(1, 3, 0, 0, 0, 0, 0, 0), "ctl_ram_kept");
    cycle(NOTE_E, 0, 0, mo(1, 3, 0, 0, 0, 0, 0, 0), "ctl_p0");
    cycle(0, 0, 0, mo(1, 3, 1, 0, 0, 0, 0, 0), "ctl_r0");

    // asynchronous reset between edges
    #3 RESET_N = 1'b0;
    #1;
    sb.push_back(mo(0, 0, 0, 0, 0, 0, 0, 0));
    check_front("async_rst");
    @(posedge CLK); #1;
    sb.push_back(mo(0, 0, 0, 0, 0, 0, 0, 0));
    check_front("rst_held");
    #2 RESET_N = 1'b1;
    cycle(0, 1, 0, mo(1, 3, 0, 0, 0, 0, 0, 0), "replay_start");
    cycle(NOTE_E, 0, 0, mo(1, 3, 0, 0, 0, 0, 0, 0), "replay_p0");
    cycle(0, 0, 0, mo(1, 3, 1, 0, 0, 0, 0, 0), "replay_r0");
    cycle(NOTE_E, 0, 0, mo(1, 3, 1, 0, 0, 0, 0, 0), "replay_p1");
    cycle(0, 0, 0, mo(1, 4, 2, 0, 0, 0, 0, 0), "replay_r1");
    cycle(NOTE_F, 0, 0, mo(1, 4, 2, 0, 0, 0, 0, 0), "replay_p2");
    cycle(0, 0, 0, mo(1, 5, 3, 0, 0, 0, 0, 0), "replay_r2");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
